// File: rtl/mult_pkg.sv
// Shared constants and FSM encoding for the sequential chunked multiplier.
package mult_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/mult_seq_nxn_if.sv
// Operand/result handshake bundle for mult_seq_nxn.
interface mult_seq_nxn_if
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic               in_valid;
  logic               in_ready;
  logic               sgn;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] prod;

  modport master (
    output in_valid, sgn, a, b, out_ready,
    input  in_ready, out_valid, prod
  );

  modport slave (
    input  in_valid, sgn, a, b, out_ready,
    output in_ready, out_valid, prod
  );

endinterface

// File: rtl/mult_chunk.sv
// Unsigned WIDTH x CHUNK partial-product multiplier (combinational).
module mult_chunk
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [WIDTH-1:0]       a_i,
  input  logic [CHUNK-1:0]       b_i,
  output logic [WIDTH+CHUNK-1:0] p_o
);

  localparam int PW = WIDTH + CHUNK;

  assign p_o = PW'(a_i) * PW'(b_i);

endmodule

// File: rtl/mult_seq_nxn.sv
// Sequential NxN multiplier: one CHUNK-bit slice of b per cycle, sign-magnitude.
module mult_seq_nxn
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  mult_seq_nxn_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0]       a_mag;
  logic [WIDTH-1:0]       b_mag;
  logic [WIDTH+CHUNK-1:0] pp;
  logic [PW-1:0]          pp_sh;
  logic [PW-1:0]          acc_sum;

  // Unary minus maps -2^(WIDTH-1) onto itself, the correct magnitude.
  assign a_mag = (bus.sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  mult_chunk #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) u_chunk (
    .a_i (a_q),
    .b_i (b_q[CHUNK-1:0]),
    .p_o (pp)
  );

  assign pp_sh   = PW'(pp) << (CHUNK * int'(cnt_q));
  assign acc_sum = acc_q + pp_sh;

  assign bus.in_ready  = (state_q == IDLE) && !clr;
  assign bus.out_valid = (state_q == DONE);
  assign bus.prod      = prod_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_d     = a_mag;
            b_d     = b_mag;
            neg_d   = bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
        CALC: begin
          // b is consumed low chunk first; its low slice feeds the multiplier.
          acc_d = acc_sum;
          b_d   = b_q >> CHUNK;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            prod_d  = neg_q ? -acc_sum : acc_sum;
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mult_seq_nxn.sv
// Bench for mult_seq_nxn: transaction model + directed vectors + width sweep.
module tb_mult_seq_nxn;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr16 = 1'b0;
  logic clr32 = 1'b0;
  logic clr24 = 1'b0;

  always #5 clk = ~clk;

  mult_seq_nxn_if #(.WIDTH(16)) m16 ();
  mult_seq_nxn_if #(.WIDTH(32)) m32 ();
  mult_seq_nxn_if #(.WIDTH(24)) m24 ();

  mult_seq_nxn #(.WIDTH(16), .CHUNK(8)) u16 (
    .clk (clk), .rst (rst), .clr (clr16), .bus (m16)
  );
  mult_seq_nxn #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk (clk), .rst (rst), .clr (clr32), .bus (m32)
  );
  mult_seq_nxn #(.WIDTH(24), .CHUNK(4)) u24 (
    .clk (clk), .rst (rst), .clr (clr24), .bus (m24)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm,
                     input longint unsigned act,
                     input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic longint unsigned ref_mul(
    input int w,
    input longint unsigned a,
    input longint unsigned b,
    input bit s
  );
    longint sa, sb;
    longint unsigned p, msk;
    if (s) begin
      sa = longint'(a << (64 - w)) >>> (64 - w);
      sb = longint'(b << (64 - w)) >>> (64 - w);
      p  = longint'(sa * sb);
    end else begin
      p = a * b;
    end
    msk = (w >= 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    return p & msk;
  endfunction

  // Transaction-level model of the 16-bit instance.
  int              ph = 0;
  int              left = 0;
  longint unsigned exp16 = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0;
    end else if (clr16) begin
      ph = 0;
    end else if (ph == 0) begin
      if (m16.in_valid) begin
        ph    = 1;
        left  = 2;
        exp16 = ref_mul(16, longint'(m16.a), longint'(m16.b), m16.sgn);
      end
    end else if (ph == 1) begin
      left--;
      if (left == 0) ph = 2;
    end else begin
      if (m16.out_ready) ph = 0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", longint'(m16.in_ready),
          longint'((ph == 0) && !clr16));
      chk("out_valid", longint'(m16.out_valid), longint'(ph == 2));
      if (ph == 2) chk("prod", longint'(m16.prod), exp16);
      if (rst) chk("rst_prod", longint'(m16.prod), 0);
    end
  end

  task automatic accept16(output bit ok);
    bit r;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      r = m16.in_ready;
      @(posedge clk);
      #1;
      if (r) ok = 1'b1;
    end
  endtask

  task automatic wait_ov16(output int lat);
    lat = 0;
    while (!m16.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b,
                      input bit s, input int hold,
                      input logic [31:0] expv);
    bit ok;
    int lat;
    m16.a = a;
    m16.b = b;
    m16.sgn = s;
    m16.in_valid = 1'b1;
    m16.out_ready = 1'b0;
    accept16(ok);
    chk("accept", longint'(ok), 1);
    m16.in_valid = 1'b0;
    m16.a = 16'($urandom);
    m16.b = 16'($urandom);
    m16.sgn = ~s;
    wait_ov16(lat);
    chk("latency", longint'(lat), 2);
    chk("lit_prod", longint'(m16.prod), longint'(expv));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_prod", longint'(m16.prod), longint'(expv));
      chk("hold_ov", longint'(m16.out_valid), 1);
      chk("hold_ir", longint'(m16.in_ready), 0);
    end
    m16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    m16.out_ready = 1'b0;
    chk("ir_after_hs", longint'(m16.in_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, r;
    int lat;
    int acc_e[$];
    logic [31:0] va32, vb32;
    logic [23:0] va24, vb24;
    bit vs;
    longint unsigned e;

    m16.in_valid = 0; m16.out_ready = 0; m16.sgn = 0;
    m16.a = 0; m16.b = 0;
    m32.in_valid = 0; m32.out_ready = 0; m32.sgn = 0;
    m32.a = 0; m32.b = 0;
    m24.in_valid = 0; m24.out_ready = 0; m24.sgn = 0;
    m24.a = 0; m24.b = 0;

    #2 rst = 1'b1;
    armed = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", longint'(m16.out_valid), 0);
    chk("rst_prod_lit", longint'(m16.prod), 0);
    rst = 1'b0;
    chk("ir_after_rst", longint'(m16.in_ready), 1);

    chk("model_a", ref_mul(16, 64'h1234, 64'h5678, 0), 64'h06260060);
    chk("model_b", ref_mul(16, 64'hFFFF, 64'hFFFF, 1), 64'h00000001);
    chk("model_c", ref_mul(16, 64'h8000, 64'h8000, 1), 64'h40000000);

    op16(16'h1234, 16'h5678, 0, 0, 32'h06260060);
    op16(16'hFFFF, 16'hFFFF, 0, 0, 32'hFFFE0001);
    op16(16'h8000, 16'h8000, 1, 0, 32'h40000000);
    op16(16'hFFFF, 16'h0001, 1, 0, 32'hFFFFFFFF);
    op16(16'hFFFF, 16'h0001, 0, 0, 32'h0000FFFF);
    op16(16'h7FFF, 16'h8000, 1, 5, 32'hC0008000);
    op16(16'hFFFF, 16'hFFFF, 1, 0, 32'h00000001);

    // Back-to-back: acceptances must be N+2 = 4 edges apart.
    m16.a = 16'h0102;
    m16.b = 16'h0304;
    m16.sgn = 1'b0;
    m16.in_valid = 1'b1;
    m16.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      r = m16.in_ready;
      @(posedge clk);
      #1;
      if (r) acc_e.push_back(k);
    end
    m16.in_valid = 1'b0;
    chk("tput_cnt", longint'(acc_e.size()), 4);
    for (int k = 1; k < acc_e.size(); k++)
      chk("tput_gap", longint'(acc_e[k] - acc_e[k-1]), 4);
    repeat (6) @(posedge clk);
    #1;
    m16.out_ready = 1'b0;

    // Abort with clr mid-CALC.
    m16.a = 16'h0003;
    m16.b = 16'h0007;
    m16.in_valid = 1'b1;
    accept16(ok);
    chk("clr_accept", longint'(ok), 1);
    m16.in_valid = 1'b0;
    clr16 = 1'b1;
    @(posedge clk);
    #1;
    clr16 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("clr_no_ov", longint'(m16.out_valid), 0);
    end

    // Abort with rst in DONE.
    m16.a = 16'h0009;
    m16.b = 16'h0009;
    m16.in_valid = 1'b1;
    accept16(ok);
    chk("rst_accept", longint'(ok), 1);
    m16.in_valid = 1'b0;
    wait_ov16(lat);
    chk("rst_pre_ov", longint'(m16.out_valid), 1);
    rst = 1'b1;
    #1;
    chk("rst_ov_drop", longint'(m16.out_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ir", longint'(m16.in_ready), 1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("rst_no_ov", longint'(m16.out_valid), 0);
    end
    op16(16'h0003, 16'h0005, 0, 0, 32'h0000000F);

    // WIDTH=32, CHUNK=8 sweep.
    for (int i = 0; i < 10; i++) begin
      va32 = (i < 2) ? 32'h80000000 : $urandom;
      vb32 = (i < 2) ? 32'h80000000 : $urandom;
      if (i == 2) vb32 = 32'hFFFFFFFF;
      vs = (i % 2) == 0;
      e = ref_mul(32, longint'(va32), longint'(vb32), vs);
      m32.a = va32;
      m32.b = vb32;
      m32.sgn = vs;
      m32.in_valid = 1'b1;
      m32.out_ready = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
        r = m32.in_ready;
        @(posedge clk);
        #1;
        if (r) ok = 1'b1;
      end
      m32.in_valid = 1'b0;
      m32.a = $urandom;
      lat = 0;
      while (!m32.out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("w32_lat", longint'(lat), 4);
      chk("w32_prod", longint'(m32.prod), e);
      @(posedge clk);
      #1;
    end
    m32.out_ready = 1'b0;

    // WIDTH=24, CHUNK=4 sweep.
    for (int i = 0; i < 10; i++) begin
      va24 = (i < 2) ? 24'h800000 : 24'($urandom);
      vb24 = (i < 2) ? 24'h800000 : 24'($urandom);
      if (i == 3) va24 = 24'hFFFFFF;
      vs = (i % 2) == 0;
      e = ref_mul(24, longint'(va24), longint'(vb24), vs);
      m24.a = va24;
      m24.b = vb24;
      m24.sgn = vs;
      m24.in_valid = 1'b1;
      m24.out_ready = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
        r = m24.in_ready;
        @(posedge clk);
        #1;
        if (r) ok = 1'b1;
      end
      m24.in_valid = 1'b0;
      m24.b = 24'($urandom);
      lat = 0;
      while (!m24.out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("w24_lat", longint'(lat), 6);
      chk("w24_prod", longint'(m24.prod), e);
      @(posedge clk);
      #1;
    end
    m24.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    armed = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_seq_nxn.md
MULT_SEQ_NXN -- requirements
Module: mult_seq_nxn

Interface
REQ-001 Parameter WIDTH, default 16, operand width; SHALL be a multiple of CHUNK and at least 2*CHUNK.
REQ-002 Parameter CHUNK, default 8, bits of operand b consumed per compute cycle.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 clr  input  1  synchronous abort; discards any operation in progress.
REQ-006 in_valid  input  1  operands and mode are valid.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 sgn  input  1  mode: 1 = two's-complement signed, 0 = unsigned; sampled with the operands.
REQ-009 a  input  WIDTH  multiplicand.
REQ-010 b  input  WIDTH  multiplier.
REQ-011 out_valid  output  1  prod holds a completed result.
REQ-012 out_ready  input  1  consumer accepts prod.
REQ-013 prod  output  2*WIDTH  product; signed or unsigned per the captured sgn.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE; N = WIDTH/CHUNK.
REQ-015 in_ready SHALL be 1 only in IDLE with clr low; out_valid SHALL be 1 only in DONE.
REQ-016 Acceptance (in_valid & in_ready at an edge) SHALL capture a, b and sgn, clear the accumulator and chunk counter, and move IDLE->CALC.
REQ-017 In signed mode, operands SHALL be captured as magnitudes and the result sign SHALL be recorded as a[MSB] XOR b[MSB]; -2^(WIDTH-1) SHALL yield magnitude 2^(WIDTH-1).
REQ-018 At CALC edge k (k = 0..N-1), the accumulator SHALL add (a_mag * b_mag chunk k) shifted left by k*CHUNK, using full 2*WIDTH-bit arithmetic with no dropped carries.
REQ-019 After the N-th CALC edge, the FSM SHALL enter DONE with prod equal to the accumulator, two's-complement negated when the recorded sign is 1.
REQ-020 Latency SHALL be exactly N edges from the acceptance edge to out_valid rising (2 for the defaults).
REQ-021 DONE SHALL hold prod and out_valid stable while out_ready is low, for any number of cycles.
REQ-022 out_valid & out_ready at an edge SHALL move DONE->IDLE; in_ready SHALL rise in the following cycle, with no same-cycle re-acceptance.
REQ-023 Throughput SHALL be one result per N+2 cycles under continuous in_valid and out_ready.
REQ-024 clr high at an edge SHALL force IDLE from any state, take priority over acceptance and completion, and produce no out_valid for the aborted operation.
REQ-025 Inputs a, b and sgn SHALL be ignored outside the acceptance edge; changing them during CALC SHALL not affect the result.
REQ-026 Unsigned mode SHALL produce the exact unsigned product for all inputs; signed mode SHALL produce the exact signed product, which always fits in 2*WIDTH bits.

Reset
REQ-027 While rst is high: FSM = IDLE, out_valid = 0, prod = 0, accumulator = 0, chunk counter = 0, captured operands and sign = 0.
REQ-028 Reset asserted mid-CALC or mid-DONE SHALL abandon the operation; no stale result SHALL appear after release.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts, provided clr is low.

Structure
REQ-030 The state encoding localparams and the default WIDTH and CHUNK constants SHALL reside in a shared package, mult_pkg.
REQ-031 The WIDTH x CHUNK unsigned partial-product multiply SHALL be a separate combinational sub-module, mult_chunk, instantiated once and reused each CALC cycle.
REQ-032 The accumulator adder SHALL propagate carries across chunk boundaries; independent per-bit XOR merging of partial products is prohibited.

Verification
REQ-033 Unsigned, a=0x1234, b=0x5678 -> prod=0x06260060, out_valid exactly 2 edges after acceptance.
REQ-034 Unsigned, a=0xFFFF, b=0xFFFF -> prod=0xFFFE0001 (checks carries across the chunk boundary).
REQ-035 Signed, a=0x8000, b=0x8000 -> 0x40000000; signed a=0xFFFF, b=0x0001 -> 0xFFFFFFFF; the same operands unsigned -> 0x0000FFFF.
REQ-036 Hold out_ready low for 5 cycles in DONE -> prod and out_valid stable; in_ready low throughout, then high one cycle after the handshake.
REQ-037 Assert clr in CALC, then rst in DONE -> no out_valid for either operation; the next operation 0x0003*0x0005 -> 0x0000000F.
REQ-038 Parameter sweep WIDTH=32, CHUNK=8, and WIDTH=24, CHUNK=4 against a random reference model (both modes) -> exact match, latency N.
